// File: rtl/elevator_call_dispatcher.sv
// Latches call buttons and issues the next floor as a one-hot target using SCAN order.
// Button to pending: 2 edges after sync; no backpressure, with new calls only ever adding to pending.
module elevator_call_dispatcher #(
    parameter int FLOORS       = 8,
    parameter int DWELL_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [FLOORS-1:0] call_btn,
    input  logic [FLOORS-1:0] cur_floor,
    output logic [FLOORS-1:0] target_floor,
    output logic [FLOORS-1:0] pending,
    output logic              busy,
    output logic              arrived,
    output logic              dir_up
);

    typedef enum logic [1:0] {S_IDLE, S_SELECT, S_TRAVEL, S_DWELL} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [FLOORS-1:0] r_sync1;
    logic [FLOORS-1:0] r_sync2;
    logic [FLOORS-1:0] r_prev;
    logic [FLOORS-1:0] r_pending;
    logic [FLOORS-1:0] r_cur_q;
    logic [FLOORS-1:0] r_target;
    logic              r_dir_up;
    logic              r_busy;
    logic              r_arrived;
    logic [7:0]        r_cnt;

    logic [FLOORS-1:0] w_rise;
    logic              w_cur_vld;
    logic [FLOORS-1:0] w_le_mask;
    logic [FLOORS-1:0] w_lt_mask;
    logic [FLOORS-1:0] w_above;
    logic [FLOORS-1:0] w_below;
    logic [FLOORS-1:0] w_above_pick;
    logic [FLOORS-1:0] w_below_pick;
    logic [FLOORS-1:0] w_sel;
    logic              w_sel_flip;
    logic              w_arrive;
    logic              w_load;
    logic [FLOORS-1:0] w_clr;

    assign w_rise    = r_sync2 & ~r_prev;
    assign w_cur_vld = (cur_floor != '0) && ((cur_floor & (cur_floor - 1'b1)) == '0);

    // cur_q one-hot: (cur_q<<1)-1 covers floors at or below it; top floor wraps to all-ones.
    assign w_le_mask    = (r_cur_q << 1) - 1'b1;
    assign w_lt_mask    = r_cur_q - 1'b1;
    assign w_above      = r_pending & ~w_le_mask;
    assign w_below      = r_pending & w_lt_mask;
    assign w_above_pick = w_above & (~w_above + 1'b1);

    always_comb begin
        w_below_pick = '0;
        for (int i = 0; i < FLOORS; i++) begin
            if (w_below[i]) begin
                w_below_pick    = '0;
                w_below_pick[i] = 1'b1;
            end
        end
    end

    always_comb begin
        w_sel      = '0;
        w_sel_flip = 1'b0;
        if ((r_pending & r_cur_q) != '0) begin
            w_sel = r_cur_q;
        end else if (r_dir_up) begin
            if (w_above != '0) begin
                w_sel = w_above_pick;
            end else if (w_below != '0) begin
                w_sel      = w_below_pick;
                w_sel_flip = 1'b1;
            end
        end else begin
            if (w_below != '0) begin
                w_sel = w_below_pick;
            end else if (w_above != '0) begin
                w_sel      = w_above_pick;
                w_sel_flip = 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_arrive    = 1'b0;
        w_load      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_pending != '0) w_state_nxt = S_SELECT;
            end
            S_SELECT: begin
                if (w_sel != '0) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_TRAVEL;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_TRAVEL: begin
                if (w_cur_vld && (cur_floor == r_target)) begin
                    w_arrive    = 1'b1;
                    w_state_nxt = S_DWELL;
                end
            end
            S_DWELL: begin
                if (r_cnt == 8'd0) w_state_nxt = S_SELECT;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_clr = w_arrive ? r_target : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_sync1   <= '0;
            r_sync2   <= '0;
            r_prev    <= '0;
            r_pending <= '0;
            r_cur_q   <= FLOORS'(1);
            r_target  <= FLOORS'(1);
            r_dir_up  <= 1'b1;
            r_busy    <= 1'b0;
            r_arrived <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_sync1   <= call_btn;
            r_sync2   <= r_sync1;
            r_prev    <= r_sync2;
            // a fresh press on the floor just reached survives the clear
            r_pending <= (r_pending & ~w_clr) | w_rise;
            r_busy    <= (w_state_nxt != S_IDLE);
            r_arrived <= w_arrive;
            if (w_cur_vld) r_cur_q <= cur_floor;
            if (w_load) begin
                r_target <= w_sel;
                if (w_sel_flip) r_dir_up <= ~r_dir_up;
            end
            if (w_arrive) begin
                r_cnt <= 8'(DWELL_CYCLES - 1);
            end else if ((r_state == S_DWELL) && (r_cnt != 8'd0)) begin
                r_cnt <= r_cnt - 8'd1;
            end
        end
    end

    assign target_floor = r_target;
    assign pending      = r_pending;
    assign busy         = r_busy;
    assign arrived      = r_arrived;
    assign dir_up       = r_dir_up;

endmodule

// File: tb/tb_elevator_call_dispatcher.sv
// Directed-vector bench for elevator_call_dispatcher (FLOORS=8, DWELL_CYCLES=4).
// Inputs change and outputs are sampled on the falling edge.
module tb_elevator_call_dispatcher;

    logic       clk;
    logic       rst;
    logic [7:0] call_btn;
    logic [7:0] cur_floor;
    logic [7:0] target_floor;
    logic [7:0] pending;
    logic       busy;
    logic       arrived;
    logic       dir_up;

    int n_vec  = 0;
    int n_miss = 0;

    elevator_call_dispatcher #(.FLOORS(8), .DWELL_CYCLES(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .call_btn     (call_btn),
        .cur_floor    (cur_floor),
        .target_floor (target_floor),
        .pending      (pending),
        .busy         (busy),
        .arrived      (arrived),
        .dir_up       (dir_up)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 40; i++) begin
            tick();
            if (!busy) break;
        end
        chk(tag, busy, 0);
    endtask

    task automatic pulse(input logic [7:0] btn);
        call_btn = btn;
        tick();
        call_btn = 8'h00;
    endtask

    initial begin
        logic seen;
        rst       = 1'b1;
        call_btn  = 8'h00;
        cur_floor = 8'h01;
        #13;
        chk("rst_target", target_floor, 8'h01);
        chk("rst_pending", pending, 8'h00);
        chk("rst_busy", busy, 0);
        chk("rst_arrived", arrived, 0);
        chk("rst_dir", dir_up, 1);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // single call to floor 4 from floor 1
        pulse(8'h08);
        tick();
        chk("a_pend_e1", pending, 8'h00);
        tick();
        chk("a_pend_e2", pending, 8'h08);
        chk("a_busy_e2", busy, 0);
        tick();
        chk("a_busy_e3", busy, 1);
        chk("a_tgt_e3", target_floor, 8'h01);
        tick();
        chk("a_tgt_e4", target_floor, 8'h08);
        chk("a_dir_e4", dir_up, 1);
        cur_floor = 8'h08;
        tick();
        chk("a_arrived", arrived, 1);
        chk("a_pend_clr", pending, 8'h00);
        tick();
        chk("a_arr_pulse", arrived, 0);
        ticks(3);
        chk("a_busy_sel", busy, 1);
        tick();
        chk("a_busy_idle", busy, 0);
        chk("a_tgt_hold", target_floor, 8'h08);

        // call at the current floor
        cur_floor = 8'h10;
        tick();
        pulse(8'h10);
        ticks(2);
        chk("c_pend", pending, 8'h10);
        tick();
        chk("c_busy", busy, 1);
        tick();
        chk("c_tgt", target_floor, 8'h10);
        chk("c_dir", dir_up, 1);
        tick();
        chk("c_arrived", arrived, 1);
        chk("c_pend_clr", pending, 8'h00);
        wait_idle("c_idle");

        // SCAN order from floor 3 with calls at floors 2 and 7
        cur_floor = 8'h04;
        tick();
        pulse(8'h42);
        ticks(2);
        chk("b_pend", pending, 8'h42);
        ticks(2);
        chk("b_tgt1", target_floor, 8'h40);
        chk("b_dir1", dir_up, 1);
        cur_floor = 8'h40;
        tick();
        chk("b_arr1", arrived, 1);
        chk("b_pend1", pending, 8'h02);
        ticks(4);
        chk("b_tgt_sel", target_floor, 8'h40);
        chk("b_busy_sel", busy, 1);
        tick();
        chk("b_tgt2", target_floor, 8'h02);
        chk("b_dir2", dir_up, 0);

        // invalid cur_floor values during travel
        cur_floor = 8'h00;
        tick();
        chk("inv0_arr", arrived, 0);
        chk("inv0_busy", busy, 1);
        cur_floor = 8'h18;
        tick();
        chk("inv18_arr", arrived, 0);
        chk("inv18_tgt", target_floor, 8'h02);
        cur_floor = 8'h02;
        tick();
        chk("b_arr2", arrived, 1);
        chk("b_pend2", pending, 8'h00);
        wait_idle("b_idle");

        // held button on floor 6
        call_btn = 8'h20;
        ticks(3);
        chk("h_pend", pending, 8'h20);
        ticks(2);
        chk("h_tgt", target_floor, 8'h20);
        chk("h_dir", dir_up, 1);
        cur_floor = 8'h20;
        tick();
        chk("h_arr", arrived, 1);
        chk("h_pend_clr", pending, 8'h00);
        seen = 1'b0;
        for (int i = 0; i < 95; i++) begin
            tick();
            if (pending[5]) seen = 1'b1;
        end
        chk("h_no_reset", seen, 0);
        chk("h_idle", busy, 0);
        call_btn = 8'h00;
        ticks(3);

        // move away to floor 1, then back to floor 6 with a re-press on arrival
        pulse(8'h01);
        ticks(3);
        tick();
        chk("m_tgt", target_floor, 8'h01);
        chk("m_dir", dir_up, 0);
        cur_floor = 8'h01;
        tick();
        chk("m_arr", arrived, 1);
        wait_idle("m_idle");
        pulse(8'h20);
        ticks(3);
        tick();
        chk("s_tgt", target_floor, 8'h20);
        chk("s_dir", dir_up, 1);
        call_btn = 8'h20;
        ticks(2);
        cur_floor = 8'h20;
        tick();
        chk("s_arr", arrived, 1);
        chk("s_setwins", pending, 8'h20);
        call_btn = 8'h00;
        wait_idle("s_idle");
        chk("s_pend_final", pending, 8'h00);

        // asynchronous reset in the middle of a move
        pulse(8'h02);
        ticks(3);
        tick();
        chk("r_tgt_pre", target_floor, 8'h02);
        chk("r_dir_pre", dir_up, 0);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("r_target", target_floor, 8'h01);
        chk("r_pending", pending, 8'h00);
        chk("r_busy", busy, 0);
        chk("r_arrived", arrived, 0);
        chk("r_dir", dir_up, 1);
        @(negedge clk);
        rst = 1'b0;
        ticks(2);
        chk("r_stay_idle", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
